cov_fetch_load: RTL and testbench

Fetches the 4×4 spatial covariance matrix of one FFT bin from the covariance estimator's read port. It applies diagonal loading (R + δI) with saturation and streams the 16 conditioned elements, row-major, to the MVDR weight solver over a valid/ready handshake. It sits directly downstream of the covariance estimator and upstream of the solver. Each request fetches one bin.

---
 rtl/mvdr_pkg.sv | 21 ++
 rtl/cov_diag_load.sv | 57 +++++
 rtl/cov_fetch_load.sv | 137 +++++++++++++
 tb/tb_cov_fetch_load.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvdr_pkg.sv
// Shared constants, Q1.15 limits and FSM state type for the MVDR covariance path.
package mvdr_pkg;
   localparam int DW    = 16;
   localparam int NMICS = 4;
   localparam int NELEM = NMICS * NMICS;
   localparam int NBINS = 129;

   localparam logic signed [DW-1:0] Q_MAX = {1'b0, {(DW-1){1'b1}}};
   localparam logic signed [DW-1:0] Q_MIN = {1'b1, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, STREAM} state_t;

   localparam logic [3:0] DIAG0 = 4'd0;
   localparam logic [3:0] DIAG1 = 4'd5;
   localparam logic [3:0] DIAG2 = 4'd10;
   localparam logic [3:0] DIAG3 = 4'd15;

   function automatic logic is_diag(input logic [3:0] idx);
      return (idx == DIAG0) || (idx == DIAG1) || (idx == DIAG2) || (idx == DIAG3);
   endfunction
endpackage

// File: rtl/cov_diag_load.sv
// Conditioning datapath: saturating diagonal load, optional Hermitian mirror (COV_HERM_EN).
module cov_diag_load
   import mvdr_pkg::*;
#(
   parameter int DW = mvdr_pkg::DW,
   parameter logic signed [DW-1:0] DELTA = 16'sd328
) (
   input  logic [3:0]           elem_idx,
   input  logic signed [DW-1:0] elem_re,
   input  logic signed [DW-1:0] elem_im,
   input  logic signed [DW-1:0] tran_re,
   input  logic signed [DW-1:0] tran_im,
   output logic signed [DW-1:0] cond_re,
   output logic signed [DW-1:0] cond_im
);
   logic signed [DW:0]   sum;
   logic signed [DW-1:0] diag_re;

   assign sum = {elem_re[DW-1], elem_re} + {DELTA[DW-1], DELTA};

   always_comb begin
      diag_re = sum[DW-1:0];
      if (sum[DW] != sum[DW-1]) diag_re = sum[DW] ? Q_MIN : Q_MAX;
   end

`ifdef COV_HERM_EN
   logic                 lower;
   logic signed [DW-1:0] neg_im;

   assign lower  = elem_idx[3:2] > elem_idx[1:0];
   assign neg_im = (tran_im == Q_MIN) ? Q_MAX : -tran_im;

   always_comb begin
      cond_re = elem_re;
      cond_im = elem_im;
      if (is_diag(elem_idx)) begin
         cond_re = diag_re;
         cond_im = '0;
      end else if (lower) begin
         cond_re = tran_re;
         cond_im = neg_im;
      end
   end
`else
   logic unused_tran;
   assign unused_tran = ^{tran_re, tran_im};

   always_comb begin
      cond_re = elem_re;
      cond_im = elem_im;
      if (is_diag(elem_idx)) begin
         cond_re = diag_re;
         cond_im = '0;
      end
   end
`endif
endmodule

// File: rtl/cov_fetch_load.sv
// Fetches one bin's 4x4 covariance, applies diagonal loading and streams it row-major.
// Optional Hermitian output via COV_HERM_EN (see cov_diag_load).
module cov_fetch_load
   import mvdr_pkg::*;
#(
   parameter int DW    = mvdr_pkg::DW,
   parameter int NBINS = mvdr_pkg::NBINS,
   parameter logic signed [DW-1:0] DELTA = 16'sd328
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [7:0]           req_bin,
   input  logic                 req_valid,
   output logic                 req_ready,
   output logic                 bad_bin,
   output logic [7:0]           rd_bin,
   output logic [3:0]           rd_elem,
   output logic                 rd_en,
   input  logic signed [DW-1:0] rd_re,
   input  logic signed [DW-1:0] rd_im,
   input  logic                 rd_valid,
   output logic signed [DW-1:0] m_re,
   output logic signed [DW-1:0] m_im,
   output logic [3:0]           m_elem,
   output logic [7:0]           m_bin,
   output logic                 m_valid,
   output logic                 m_last,
   input  logic                 m_ready,
   output logic                 busy
);
   localparam logic [8:0] NBINS_W = 9'(NBINS);

   state_t               state, state_nxt;
   logic [3:0]           cap_cnt;
   logic                 accept, bad, cap_en;
   logic [3:0]           nxt_elem, tr_elem;
   logic signed [DW-1:0] buf_re [NELEM];
   logic signed [DW-1:0] buf_im [NELEM];
   logic signed [DW-1:0] c_re, c_im;

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      bad       = 1'b0;
      cap_en    = ((state == FETCH) || (state == DRAIN)) && rd_valid;
      // First STREAM cycle loads element 0; afterwards the register pre-loads the next beat.
      nxt_elem  = m_valid ? m_elem + 4'd1 : 4'd0;
      tr_elem   = {nxt_elem[1:0], nxt_elem[3:2]};
      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               if ({1'b0, req_bin} >= NBINS_W) begin
                  bad = 1'b1;
               end else begin
                  accept    = 1'b1;
                  state_nxt = FETCH;
               end
            end
         end
         FETCH:   if (rd_elem == 4'd15) state_nxt = DRAIN;
         DRAIN:   state_nxt = STREAM;
         STREAM:  if (m_valid && m_ready && m_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_ready <= 1'b1;
         busy      <= 1'b0;
         bad_bin   <= 1'b0;
         rd_en     <= 1'b0;
         rd_bin    <= '0;
         rd_elem   <= '0;
         cap_cnt   <= '0;
         m_valid   <= 1'b0;
         m_last    <= 1'b0;
         m_re      <= '0;
         m_im      <= '0;
         m_elem    <= '0;
         m_bin     <= '0;
      end else begin
         req_ready <= (state_nxt == IDLE);
         busy      <= (state_nxt != IDLE);
         bad_bin   <= bad;
         if (accept) begin
            rd_bin  <= req_bin;
            rd_elem <= '0;
            rd_en   <= 1'b1;
            cap_cnt <= '0;
         end else if (state == FETCH) begin
            if (rd_elem == 4'd15) begin
               rd_en   <= 1'b0;
               rd_elem <= '0;
            end else begin
               rd_elem <= rd_elem + 4'd1;
            end
         end
         if (cap_en) cap_cnt <= cap_cnt + 4'd1;
         if ((state == STREAM) && (!m_valid || m_ready)) begin
            if (m_valid && m_last) begin
               m_valid <= 1'b0;
               m_last  <= 1'b0;
            end else begin
               m_valid <= 1'b1;
               m_elem  <= nxt_elem;
               m_last  <= (nxt_elem == 4'd15);
               m_re    <= c_re;
               m_im    <= c_im;
               if (!m_valid) m_bin <= rd_bin;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (cap_en) begin
         buf_re[cap_cnt] <= rd_re;
         buf_im[cap_cnt] <= rd_im;
      end
   end

   cov_diag_load #(.DW(DW), .DELTA(DELTA)) u_diag (
      .elem_idx (nxt_elem),
      .elem_re  (buf_re[nxt_elem]),
      .elem_im  (buf_im[nxt_elem]),
      .tran_re  (buf_re[tr_elem]),
      .tran_im  (buf_im[tr_elem]),
      .cond_re  (c_re),
      .cond_im  (c_im)
   );
endmodule

// File: tb/tb_cov_fetch_load.sv
// Directed bench for cov_fetch_load with a one-cycle-latency covariance RAM model.
module tb_cov_fetch_load;
   logic               clk = 1'b0;
   logic               rst_n;
   logic [7:0]         req_bin;
   logic               req_valid;
   logic               req_ready, bad_bin;
   logic [7:0]         rd_bin;
   logic [3:0]         rd_elem;
   logic               rd_en;
   logic signed [15:0] rd_re, rd_im;
   logic               rd_valid;
   logic signed [15:0] m_re, m_im;
   logic [3:0]         m_elem;
   logic [7:0]         m_bin;
   logic               m_valid, m_last, m_ready, busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc[$];
   int rd_en_cnt, rdbin_err, bad_cnt, busy_cnt, exp_bin;
   logic signed [15:0] ram_re [16];
   logic signed [15:0] ram_im [16];
   int got_re [16];
   int got_im [16];

   always #5 clk = ~clk;

   cov_fetch_load dut (
      .clk(clk), .rst_n(rst_n), .req_bin(req_bin), .req_valid(req_valid),
      .req_ready(req_ready), .bad_bin(bad_bin), .rd_bin(rd_bin), .rd_elem(rd_elem),
      .rd_en(rd_en), .rd_re(rd_re), .rd_im(rd_im), .rd_valid(rd_valid),
      .m_re(m_re), .m_im(m_im), .m_elem(m_elem), .m_bin(m_bin),
      .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready), .busy(busy)
   );

   task automatic chk(input string tag, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   // RAM model: data for the address presented in one cycle appears in the next.
   initial begin
      logic       v;
      logic [3:0] e;
      rd_valid = 1'b0;
      rd_re = '0;
      rd_im = '0;
      forever begin
         @(posedge clk);
         v = rd_en;
         e = rd_elem;
         #1;
         rd_valid = v;
         rd_re = v ? ram_re[e] : 16'sd0;
         rd_im = v ? ram_im[e] : 16'sd0;
      end
   end

   initial forever begin
      @(posedge clk);
      cyc++;
      if (req_valid && req_ready) acc.push_back(cyc);
   end

   initial forever begin
      @(negedge clk);
      if (rd_en) begin
         rd_en_cnt++;
         if (int'(rd_bin) != exp_bin) rdbin_err++;
      end
      if (bad_bin) bad_cnt++;
      if (busy) busy_cnt++;
   end

   function automatic int sat16(input int s);
      return (s > 32767) ? 32767 : ((s < -32768) ? -32768 : s);
   endfunction

   function automatic int exp_re(input int k);
      int r = k / 4, c = k % 4;
      if (r == c) return sat16(int'(ram_re[k]) + 328);
`ifdef COV_HERM_EN
      if (r > c) return int'(ram_re[c*4+r]);
`endif
      return int'(ram_re[k]);
   endfunction

   function automatic int exp_im(input int k);
      int r = k / 4, c = k % 4;
      if (r == c) return 0;
`ifdef COV_HERM_EN
      if (r > c) return sat16(-int'(ram_im[c*4+r]));
`endif
      return int'(ram_im[k]);
   endfunction

   task automatic clear_mon();
      rd_en_cnt = 0;
      rdbin_err = 0;
      bad_cnt = 0;
      busy_cnt = 0;
   endtask

   task automatic request(input int b);
      @(negedge clk);
      req_bin = 8'(b);
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic collect(input int nbeats, input bit stall);
      int beat = 0;
      int guard = 0;
      bit held = 0;
      int h_re = 0, h_im = 0, h_e = 0, h_l = 0;
      while (beat < nbeats && guard < 400) begin
         @(negedge clk);
         guard++;
         if (held) begin
            chk("hold_valid", int'(m_valid), 1);
            chk("hold_re", int'(m_re), h_re);
            chk("hold_im", int'(m_im), h_im);
            chk("hold_elem", int'(m_elem), h_e);
            chk("hold_last", int'(m_last), h_l);
            held = 0;
         end
         m_ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
         if (m_valid && m_ready) begin
            chk("beat_elem", int'(m_elem), beat);
            chk("beat_re", int'(m_re), exp_re(beat));
            chk("beat_im", int'(m_im), exp_im(beat));
            chk("beat_last", int'(m_last), (beat == 15) ? 1 : 0);
            chk("beat_bin", int'(m_bin), exp_bin);
            got_re[beat] = int'(m_re);
            got_im[beat] = int'(m_im);
            beat++;
         end else if (m_valid) begin
            held = 1;
            h_re = int'(m_re);
            h_im = int'(m_im);
            h_e = int'(m_elem);
            h_l = int'(m_last);
         end
      end
      if (beat < nbeats) chk("stream_timeout", beat, nbeats);
   endtask

   task automatic drain();
      int guard = 0;
      @(negedge clk);
      while (busy && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      chk("drain_busy", int'(busy), 0);
      chk("drain_req_ready", int'(req_ready), 1);
   endtask

   task automatic load_basic();
      for (int k = 0; k < 16; k++) begin
         ram_re[k] = 16'(k * 100);
         ram_im[k] = 16'(-k);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req_bin = '0;
      req_valid = 1'b0;
      m_ready = 1'b0;
      exp_bin = 0;
      clear_mon();
      load_basic();
      repeat (3) @(negedge clk);
      chk("rst_rd_en", int'(rd_en), 0);
      chk("rst_rd_bin", int'(rd_bin), 0);
      chk("rst_rd_elem", int'(rd_elem), 0);
      chk("rst_m_valid", int'(m_valid), 0);
      chk("rst_m_last", int'(m_last), 0);
      chk("rst_m_re", int'(m_re), 0);
      chk("rst_m_im", int'(m_im), 0);
      chk("rst_m_elem", int'(m_elem), 0);
      chk("rst_m_bin", int'(m_bin), 0);
      chk("rst_bad_bin", int'(bad_bin), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_req_ready", int'(req_ready), 1);
      rst_n = 1'b1;

      // basic fetch of bin 3
      exp_bin = 3;
      m_ready = 1'b1;
      clear_mon();
      request(3);
      collect(16, 0);
      drain();
      chk("basic_rd_en_cycles", rd_en_cnt, 16);
      chk("basic_rd_bin", rdbin_err, 0);
      chk("basic_e0_re", got_re[0], 328);
      chk("basic_e5_re", got_re[5], 828);
      chk("basic_e5_im", got_im[5], 0);
      chk("basic_e1_re", got_re[1], 100);
      chk("basic_e1_im", got_im[1], -1);

      // back-to-back period with req_valid held
      acc.delete();
      @(negedge clk);
      req_bin = 8'd3;
      req_valid = 1'b1;
      m_ready = 1'b1;
      for (int i = 0; i < 200 && acc.size() < 2; i++) @(negedge clk);
      req_valid = 1'b0;
      chk("period_accepts", acc.size(), 2);
      if (acc.size() >= 2) chk("period_cycles", acc[1] - acc[0], 35);
      drain();

      // saturation with random backpressure
      exp_bin = 7;
      ram_re[10] = 16'sd32700;  ram_im[10] = 16'sd50;
      ram_re[0]  = -16'sd32768; ram_im[0]  = 16'sd5;
      ram_re[15] = 16'sd32767;  ram_im[15] = -16'sd1;
      request(7);
      collect(16, 1);
      drain();
      chk("sat_e10_re", got_re[10], 32767);
      chk("sat_e10_im", got_im[10], 0);
      chk("sat_e0_re", got_re[0], -32440);
      chk("sat_e15_re", got_re[15], 32767);

      // Hermitian mirror
      exp_bin = 9;
      load_basic();
      ram_re[1] = 16'sd200;     ram_im[1] = 16'sd300;
      ram_re[4] = 16'sd7;       ram_im[4] = 16'sd7;
      ram_re[2] = 16'sd5;       ram_im[2] = -16'sd32768;
      ram_re[8] = 16'sd1;       ram_im[8] = 16'sd1;
      request(9);
      collect(16, 1);
      drain();
`ifdef COV_HERM_EN
      chk("herm_e4_re", got_re[4], 200);
      chk("herm_e4_im", got_im[4], -300);
      chk("herm_e8_im", got_im[8], 32767);
`else
      chk("herm_e4_re", got_re[4], 7);
      chk("herm_e4_im", got_im[4], 7);
      chk("herm_e8_im", got_im[8], 1);
`endif
      chk("herm_e1_im", got_im[1], 300);

      // rejected bin
      clear_mon();
      @(negedge clk);
      req_bin = 8'd129;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (5) @(negedge clk);
      chk("bad_pulses", bad_cnt, 1);
      chk("bad_rd_en", rd_en_cnt, 0);
      chk("bad_busy", busy_cnt, 0);
      chk("bad_req_ready", int'(req_ready), 1);

      // reset during STREAM after beat 6, then restart on the last valid bin
      exp_bin = 128;
      load_basic();
      request(128);
      collect(7, 0);
      @(posedge clk);
      #2 m_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("srst_m_valid", int'(m_valid), 0);
      chk("srst_m_last", int'(m_last), 0);
      chk("srst_m_elem", int'(m_elem), 0);
      chk("srst_m_re", int'(m_re), 0);
      chk("srst_m_im", int'(m_im), 0);
      chk("srst_m_bin", int'(m_bin), 0);
      chk("srst_rd_en", int'(rd_en), 0);
      chk("srst_busy", int'(busy), 0);
      chk("srst_req_ready", int'(req_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      clear_mon();
      request(128);
      collect(16, 0);
      drain();
      chk("restart_rd_en_cycles", rd_en_cnt, 16);
      chk("restart_rd_bin", rdbin_err, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
